// File: rtl/mul_div_unit.sv
// mul_div_unit
//   Iterative unsigned multiply/divide for the execute stage. One bit-step per
//   clock, W steps per operation, registered result feeding write-back.
//
//   Ports:
//     clk        rising-edge clock
//     rst        synchronous active-high reset
//     start      request an operation (accepted in IDLE or DONE only)
//     op         00 MUL, 01 MULHU, 10 DIVU, 11 REMU
//     operand_a  multiplicand / dividend
//     operand_b  multiplier / divisor
//     busy       operation in progress
//     done       one-cycle pulse, result is new
//     result     registered result, held until next completion or reset
module mul_div_unit #(
  parameter int BUS_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [1:0]           op,
  input  logic [BUS_WIDTH-1:0] operand_a,
  input  logic [BUS_WIDTH-1:0] operand_b,
  output logic                 busy,
  output logic                 done,
  output logic [BUS_WIDTH-1:0] result
);

  localparam int W  = BUS_WIDTH;
  localparam int CW = $clog2(W + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state;
  logic [1:0]    op_q;
  logic [CW-1:0] cnt;
  // opnd holds the multiplicand for multiplies and the divisor for divides.
  // acc low half starts as the multiplier (MUL) or dividend (DIV); for divide
  // it shifts out dividend bits at the top while quotient bits enter at bit 0.
  logic [W-1:0]   opnd;
  logic [2*W-1:0] acc;
  logic [W-1:0]   rem;

  logic [2*W-1:0] acc_nxt;
  logic [W-1:0]   rem_nxt;
  logic [W:0]     mul_sum;
  logic [W:0]     div_shift;
  logic [W-1:0]   div_diff;
  logic           div_ge;
  logic           accept;
  logic           last;
  logic [W-1:0]   res_nxt;

  // Shift-add: add multiplicand into the high half when the current
  // multiplier bit (acc[0]) is set, then shift the whole accumulator right,
  // keeping the carry as the new top bit.
  assign mul_sum = {1'b0, acc[2*W-1:W]} + {1'b0, (acc[0] ? opnd : {W{1'b0}})};

  // Restoring division step. The remainder before the shift is always below
  // the divisor (or, for b=0, a prefix of the dividend), so W stored bits
  // suffice; the shifted value needs W+1. The difference fits in W bits
  // whenever it is taken.
  assign div_shift = {rem, acc[W-1]};
  assign div_ge    = (div_shift >= {1'b0, opnd});
  assign div_diff  = div_shift[W-1:0] - opnd;

  always_comb begin
    acc_nxt = acc;
    rem_nxt = rem;
    if (!op_q[1]) begin
      acc_nxt = {mul_sum, acc[W-1:1]};
    end else begin
      acc_nxt = {acc[2*W-1:W], acc[W-2:0], div_ge};
      rem_nxt = div_ge ? div_diff : div_shift[W-1:0];
    end
  end

  always_comb begin
    res_nxt = acc_nxt[W-1:0];
    case (op_q)
      2'b00:   res_nxt = acc_nxt[W-1:0];
      2'b01:   res_nxt = acc_nxt[2*W-1:W];
      2'b10:   res_nxt = acc_nxt[W-1:0];
      default: res_nxt = rem_nxt;
    endcase
  end

  assign accept = start && ((state == S_IDLE) || (state == S_DONE));
  assign last   = (cnt == CW'(W - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      op_q   <= 2'b00;
      cnt    <= '0;
      opnd   <= '0;
      acc    <= '0;
      rem    <= '0;
      result <= '0;
    end else begin
      case (state)
        S_BUSY: begin
          acc <= acc_nxt;
          rem <= rem_nxt;
          cnt <= cnt + CW'(1);
          if (last) begin
            state  <= S_DONE;
            result <= res_nxt;
          end
        end
        default: begin
          if (accept) begin
            state <= S_BUSY;
            op_q  <= op;
            cnt   <= '0;
            rem   <= '0;
            opnd  <= op[1] ? operand_b : operand_a;
            acc   <= {{W{1'b0}}, (op[1] ? operand_a : operand_b)};
          end else begin
            state <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign busy = (state == S_BUSY);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_mul_div_unit.sv
module tb_mul_div_unit;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] operand_a;
  logic [W-1:0] operand_b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;

  int checks = 0;
  int errors = 0;

  mul_div_unit #(.BUS_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .operand_a(operand_a), .operand_b(operand_b),
    .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  // advance one edge, sample 1 time unit later
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation from IDLE and wait (bounded) for done.
  // lat counts edges after the accept edge; bsy counts cycles busy was seen.
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b, output logic [W-1:0] res,
                        output int lat, output int bsy, output int both);
    op = o; operand_a = a; operand_b = b; start = 1'b1;
    tick();
    start = 1'b0; operand_a = 8'h00; operand_b = 8'h00; op = 2'b00;
    lat = 0; bsy = 0; both = 0;
    while (!done && lat < 40) begin
      if (busy) bsy++;
      tick();
      lat++;
      if (busy && done) both++;
    end
    res = result;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; op = 2'b00; operand_a = '0; operand_b = '0;
    tick(); tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (result !== 8'h00) begin errors++; $display("FAIL reset_result got %h want 00", result); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_mul();
    logic [W-1:0] r; int lat, bsy, both;
    run_op(2'b00, 8'd13, 8'd11, r, lat, bsy, both);
    checks++; if (r !== 8'h8F) begin errors++; $display("FAIL mul_result got %h want 8f", r); end
    checks++; if (lat !== 8) begin errors++; $display("FAIL mul_latency got %0d want 8", lat); end
    checks++; if (bsy !== 8) begin errors++; $display("FAIL mul_busy_cycles got %0d want 8", bsy); end
    checks++; if (both !== 0) begin errors++; $display("FAIL mul_busy_done_overlap got %0d want 0", both); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL mul_done_pulse got %b want 0", done); end
    repeat (4) tick();
    checks++; if (result !== 8'h8F) begin errors++; $display("FAIL mul_result_hold got %h want 8f", result); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] r; int lat, bsy, both, gap;
    run_op(2'b01, 8'hFF, 8'hFF, r, lat, bsy, both);
    checks++; if (r !== 8'hFE) begin errors++; $display("FAIL mulhu_result got %h want fe", r); end
    // still in DONE: re-issue immediately
    op = 2'b00; operand_a = 8'hFF; operand_b = 8'hFF; start = 1'b1;
    tick();
    start = 1'b0;
    gap = 1;
    while (!done && gap < 40) begin tick(); gap++; end
    checks++; if (gap !== 9) begin errors++; $display("FAIL b2b_gap got %0d want 9", gap); end
    checks++; if (result !== 8'h01) begin errors++; $display("FAIL b2b_mul_result got %h want 01", result); end
    tick();
  endtask

  task automatic test_div();
    logic [W-1:0] r; int lat, bsy, both;
    run_op(2'b10, 8'd200, 8'd7, r, lat, bsy, both);
    checks++; if (r !== 8'h1C) begin errors++; $display("FAIL divu_200_7 got %h want 1c", r); end
    checks++; if (lat !== 8) begin errors++; $display("FAIL divu_latency got %0d want 8", lat); end
    tick();
    run_op(2'b11, 8'd200, 8'd7, r, lat, bsy, both);
    checks++; if (r !== 8'h04) begin errors++; $display("FAIL remu_200_7 got %h want 04", r); end
    tick();
    run_op(2'b10, 8'd5, 8'd9, r, lat, bsy, both);
    checks++; if (r !== 8'h00) begin errors++; $display("FAIL divu_5_9 got %h want 00", r); end
    tick();
    run_op(2'b11, 8'd5, 8'd9, r, lat, bsy, both);
    checks++; if (r !== 8'h05) begin errors++; $display("FAIL remu_5_9 got %h want 05", r); end
    tick();
  endtask

  task automatic test_div_zero();
    logic [W-1:0] r; int lat, bsy, both;
    run_op(2'b10, 8'h5A, 8'h00, r, lat, bsy, both);
    checks++; if (r !== 8'hFF) begin errors++; $display("FAIL divu_by_zero got %h want ff", r); end
    checks++; if (lat !== 8) begin errors++; $display("FAIL divu_by_zero_latency got %0d want 8", lat); end
    tick();
    run_op(2'b11, 8'h5A, 8'h00, r, lat, bsy, both);
    checks++; if (r !== 8'h5A) begin errors++; $display("FAIL remu_by_zero got %h want 5a", r); end
    tick();
  endtask

  task automatic test_start_while_busy();
    int lat, extra;
    op = 2'b00; operand_a = 8'd13; operand_b = 8'd11; start = 1'b1;
    tick();
    start = 1'b0; lat = 0;
    tick(); tick(); lat = 2;
    // third busy cycle: try to start a different operation
    op = 2'b10; operand_a = 8'd100; operand_b = 8'd3; start = 1'b1;
    tick(); lat++;
    start = 1'b0;
    while (!done && lat < 40) begin tick(); lat++; end
    checks++; if (lat !== 8) begin errors++; $display("FAIL swb_latency got %0d want 8", lat); end
    checks++; if (result !== 8'h8F) begin errors++; $display("FAIL swb_result got %h want 8f", result); end
    extra = 0;
    repeat (12) begin tick(); if (done || busy) extra++; end
    checks++; if (extra !== 0) begin errors++; $display("FAIL swb_second_op got %0d active cycles want 0", extra); end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] r; int lat, bsy, both;
    // previous result is 0x8F, so a forced clear is observable
    op = 2'b00; operand_a = 8'hFF; operand_b = 8'h03; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rstmid_done got %b want 0", done); end
    checks++; if (result !== 8'h00) begin errors++; $display("FAIL rstmid_result got %h want 00", result); end
    both = 0;
    repeat (10) begin tick(); if (done) both++; end
    checks++; if (both !== 0) begin errors++; $display("FAIL rstmid_stray_done got %0d want 0", both); end
    run_op(2'b00, 8'h12, 8'h0A, r, lat, bsy, both);
    checks++; if (r !== 8'hB4) begin errors++; $display("FAIL rstmid_next_result got %h want b4", r); end
    checks++; if (lat !== 8) begin errors++; $display("FAIL rstmid_next_latency got %0d want 8", lat); end
    tick();
  endtask

  initial begin
    test_reset();
    test_mul();
    test_back_to_back();
    test_div();
    test_div_zero();
    test_start_while_busy();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
